tff_bank_arbiter: RTL and testbench

TFF_BANK_ARBITER -- requirements
Module: tff_bank_arbiter

---
 rtl/tff_bank_arbiter.sv | 99 +++++++++
 tb/tb_tff_bank_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter granting N_REQ requesters exclusive access to a bank of
// WIDTH toggle flip-flops; each grant applies one latched toggle mask and acks.
module tff_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   mask,
    input  logic                     clr,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qb,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]    LAST_RESET = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        ACK
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   last_granted;
    logic [IW-1:0]   cur_idx;
    logic [IW-1:0]   sel_idx;
    logic [IW:0]     cand;
    logic            found;
    logic [WIDTH-1:0] latched_mask;

    // Search upward from the requester after the last one served, wrapping.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_granted} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ))
                cand = cand - (IW+1)'(N_REQ);
            if (!found && req[cand[IW-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = APPLY;
            APPLY:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // clr wins over a toggle landing on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt          <= '0;
            cur_idx      <= '0;
            last_granted <= LAST_RESET;
            latched_mask <= '0;
            q            <= '0;
        end else begin
            if (state == IDLE && found) begin
                gnt          <= ONE_HOT0 << sel_idx;
                cur_idx      <= sel_idx;
                latched_mask <= mask[sel_idx*WIDTH +: WIDTH];
            end
            if (state == ACK) begin
                gnt          <= '0;
                last_granted <= cur_idx;
            end
            if (clr)
                q <= '0;
            else if (state == APPLY)
                q <= q ^ latched_mask;
        end
    end

    assign ack  = (state == ACK) ? gnt : '0;
    assign qb   = ~q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Self-checking bench for tff_bank_arbiter: directed scenarios plus randomized
// transactions compared against a round-robin / XOR reference model.
module tb_tff_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] mask = '0;
    logic           clr = 1'b0;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   q, qb;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int model_last;
    logic [W-1:0] model_q;

    always #5 clk = ~clk;

    tff_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .mask (mask),
        .clr  (clr),
        .gnt  (gnt),
        .ack  (ack),
        .q    (q),
        .qb   (qb),
        .busy (busy)
    );

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = '0; mask = '0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_last = N - 1;
        model_q = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, busy} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: gnt/ack/busy=%b expected 0", {gnt, ack, busy});
        end
        checks++;
        if (q !== 8'h00 || qb !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_q: q=%h qb=%h expected 00/ff", q, qb);
        end
        @(negedge clk);
        rst = 1'b1;
        model_last = N - 1;
        model_q = '0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req = 4'b0001; mask[7:0] = 8'hA5;
        @(posedge clk); #1;
        checks++;
        if ({gnt, ack, busy} !== {4'b0001, 4'b0000, 1'b1}) begin
            errors++;
            $display("[TB] FAIL single_grant: gnt=%b ack=%b busy=%b expected 0001/0000/1", gnt, ack, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 8'hA5 || {gnt, ack, busy} !== {4'b0001, 4'b0001, 1'b1}) begin
            errors++;
            $display("[TB] FAIL single_apply: q=%h gnt=%b ack=%b busy=%b expected a5/0001/0001/1", q, gnt, ack, busy);
        end
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        checks++;
        if ({gnt, ack, busy} !== 9'b0 || qb !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL single_done: gnt=%b ack=%b busy=%b qb=%h expected 0/0/0/5a", gnt, ack, busy, qb);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        logic [W-1:0] exp_q;
        do_reset();
        @(negedge clk);
        req = 4'b1111; mask = {4{8'h01}};
        for (int t = 0; t < 15; t++) begin
            @(posedge clk); #1;
            exp_g = (t % 3 == 2) ? 4'b0000 : 4'(1 << ((t / 3) % 4));
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("[TB] FAIL rr_gnt t=%0d: gnt=%b expected %b", t, gnt, exp_g);
            end
            if (t % 3 == 1) begin
                exp_q = ((t / 3) % 2 == 0) ? 8'h01 : 8'h00;
                checks++;
                if (q !== exp_q || ack !== exp_g) begin
                    errors++;
                    $display("[TB] FAIL rr_toggle t=%0d: q=%h ack=%b expected %h/%b", t, q, ack, exp_q, exp_g);
                end
            end
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_clr_override();
        do_reset();
        @(negedge clk);
        req = 4'b0100; mask[23:16] = 8'h0F;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL clr_setup: q=%h expected 0f", q);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        req = 4'b0100; mask[23:16] = 8'hFF;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL clr_grant: gnt=%b expected 0100", gnt);
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h00 || ack !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL clr_override: q=%h ack=%b expected 00/0100", q, ack);
        end
        @(negedge clk);
        clr = 1'b0; req = '0;
        @(posedge clk); #1;
        checks++;
        if ({gnt, ack, busy} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL clr_done: gnt=%b ack=%b busy=%b expected idle", gnt, ack, busy);
        end
    endtask

    task automatic test_mask_change();
        do_reset();
        @(negedge clk);
        req = 4'b0010; mask[15:8] = 8'h3C;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL mask_grant: gnt=%b expected 0010", gnt);
        end
        @(negedge clk);
        req = '0; mask = '1;
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h3C || ack !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL mask_latched: q=%h ack=%b expected 3c/0010", q, ack);
        end
        @(posedge clk); #1;
        // Zero mask: handshake happens, q untouched; search resumes after 1.
        @(negedge clk);
        req = 4'b0001; mask = '0;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_grant: gnt=%b busy=%b expected 0001/1", gnt, busy);
        end
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h3C || ack !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL zero_mask: q=%h ack=%b expected 3c/0001", q, ack);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        req = 4'b1000; mask[31:24] = 8'h11;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (q !== 8'h11) begin
            errors++;
            $display("[TB] FAIL areset_setup: q=%h expected 11", q);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        req = 4'b1000; mask[31:24] = 8'h22;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL areset_grant: gnt=%b expected 1000", gnt);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, busy} !== 9'b0 || q !== 8'h00 || qb !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL areset_mid: gnt=%b ack=%b busy=%b q=%h expected all cleared", gnt, ack, busy, q);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        rst = 1'b1; req = 4'b1001;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL areset_restart: gnt=%b expected 0001", gnt);
        end
        @(negedge clk);
        req = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random(input int count);
        int           w;
        logic [N-1:0] r, exp_g;
        logic [W-1:0] exp_mask;
        logic         c;
        do_reset();
        for (int n = 0; n < count; n++) begin
            @(negedge clk);
            clr = 1'b0;
            if ($urandom % 5 == 0) begin
                req = '0;
                mask = $urandom;
                c = ($urandom % 2 == 0);
                clr = c;
                if (c) model_q = '0;
                @(posedge clk); #1;
                checks++;
                if ({gnt, ack, busy} !== 9'b0 || q !== model_q) begin
                    errors++;
                    $display("[TB] FAIL rand_idle n=%0d: gnt=%b ack=%b busy=%b q=%h expected idle q=%h", n, gnt, ack, busy, q, model_q);
                end
                continue;
            end
            r = 4'($urandom_range(1, 15));
            req = r;
            mask = ($urandom % 4 == 0) ? '0 : $urandom;
            w = rr_pick(model_last, r);
            exp_mask = mask[w*W +: W];
            exp_g = 4'(1 << w);
            @(posedge clk); #1;
            checks++;
            if ({gnt, ack, busy} !== {exp_g, 4'b0000, 1'b1}) begin
                errors++;
                $display("[TB] FAIL rand_grant n=%0d: gnt=%b ack=%b busy=%b expected %b/0000/1", n, gnt, ack, busy, exp_g);
            end
            @(negedge clk);
            mask = $urandom;
            req = 4'($urandom);
            c = ($urandom % 4 == 0);
            clr = c;
            model_q = c ? '0 : (model_q ^ exp_mask);
            @(posedge clk); #1;
            checks++;
            if (q !== model_q || qb !== ~model_q || {gnt, ack, busy} !== {exp_g, exp_g, 1'b1}) begin
                errors++;
                $display("[TB] FAIL rand_apply n=%0d: q=%h gnt=%b ack=%b busy=%b expected q=%h %b/%b/1", n, q, gnt, ack, busy, model_q, exp_g, exp_g);
            end
            @(negedge clk);
            c = ($urandom % 6 == 0);
            clr = c;
            req = '0;
            if (c) model_q = '0;
            @(posedge clk); #1;
            checks++;
            if ({gnt, ack, busy} !== 9'b0 || q !== model_q) begin
                errors++;
                $display("[TB] FAIL rand_done n=%0d: gnt=%b ack=%b busy=%b q=%h expected idle q=%h", n, gnt, ack, busy, q, model_q);
            end
            model_last = w;
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_clr_override();
        test_mask_change();
        test_async_reset();
        test_random(60);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
